// File: rtl/num_disp_scan_if.sv
// Host/pin bundle for num_disp_scan: load strobe, value, blank, and the
// registered segment/anode/index outputs.
interface num_disp_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    blank;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [1:0]              digit_idx;

    modport master (output load, value_in, blank, input  seg_n, an_n, digit_idx);
    modport slave  (input  load, value_in, blank, output seg_n, an_n, digit_idx);
endinterface

// File: rtl/num_disp_scan.sv
// Multiplexed four-digit hex 7-segment scanner with registered outputs.
// Optional leading-zero blanking is enabled by defining NUM_DISP_LZB_EN.
module num_disp_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 27000
) (
    input  logic           clk,
    input  logic           reset_n,
    num_disp_scan_if.slave disp
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_e;

    logic [4*NUM_DIGITS-1:0] val_q;
    logic [CNT_W-1:0]        cnt;
    dig_e                    idx;
    logic                    tick;
    logic [3:0]              nibble;
    logic                    suppress;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
            4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
            4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
            4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
        endcase
        return f;
    endfunction

    assign tick   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign nibble = val_q[4*idx +: 4];

`ifdef NUM_DISP_LZB_EN
    // A digit goes dark when it and every more-significant nibble are zero.
    assign suppress = (idx != DIG0) && ((val_q >> (4*idx)) == '0);
`else
    assign suppress = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain idx into the outputs early.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q <= '0;
            cnt   <= '0;
        end else begin
            if (disp.load) val_q <= disp.value_in;
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Scan ring plus output stage; outputs lag idx by exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx            <= DIG0;
            disp.an_n      <= '1;
            disp.seg_n     <= '1;
            disp.digit_idx <= '0;
        end else begin
            if (tick) begin
                case (idx)
                    DIG0:    idx <= DIG1;
                    DIG1:    idx <= DIG2;
                    DIG2:    idx <= DIG3;
                    default: idx <= DIG0;
                endcase
            end
            disp.digit_idx <= idx;
            if (disp.blank || suppress) begin
                disp.an_n  <= '1;
                disp.seg_n <= '1;
            end else begin
                disp.an_n  <= ~(NUM_DIGITS'(1) << idx);
                disp.seg_n <= ~font(nibble);
            end
        end
    end
endmodule

// File: tb/tb_num_disp_scan.sv
// Self-checking bench for num_disp_scan (REFRESH_DIV=4): table vectors,
// hand-written corner sequences and random traffic against a cycle-count model.
module tb_num_disp_scan;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    num_disp_scan_if #(.NUM_DIGITS(4)) disp ();

    num_disp_scan #(.NUM_DIGITS(4), .REFRESH_DIV(R)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .disp    (disp)
    );

    always #5 clk = ~clk;

    // Model state: loaded value and number of edges seen since reset release.
    logic [15:0] m_val;
    int          m_edges;
    logic [12:0] exp_out;

    logic [6:0] font_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0]     value;
        logic [3:0][6:0] seg;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs after an edge that had e earlier edges: slot e/R, value as loaded.
    function automatic logic [12:0] model_out(input logic [15:0] v, input int e, input logic b);
        int         slot;
        logic [3:0] nib;
        logic       dark;
        logic [3:0] an;
        logic [6:0] seg;
        slot = (e / R) % 4;
        nib  = 4'((v >> (4 * slot)) & 16'hF);
        dark = b;
`ifdef NUM_DISP_LZB_EN
        if (slot > 0 && (v >> (4 * slot)) == 16'h0) dark = 1'b1;
`endif
        an  = dark ? 4'hF : ~(4'b0001 << slot);
        seg = dark ? 7'h7F : ~font_tbl[nib];
        return {2'(slot), an, seg};
    endfunction

    task automatic step();
        @(posedge clk);
        exp_out = model_out(m_val, m_edges, disp.blank);
        if (disp.load) m_val = disp.value_in;
        m_edges++;
        @(negedge clk);
        check("scan", {3'b0, disp.digit_idx, disp.an_n, disp.seg_n}, {3'b0, exp_out});
        check("onehot", {15'b0, (disp.an_n == 4'hF) || $onehot(~disp.an_n)}, 16'h1);
    endtask

    task automatic do_reset();
        disp.load = 1'b0; disp.blank = 1'b0; disp.value_in = 16'h0;
        reset_n = 1'b0;
        #3;
        check("reset", {3'b0, disp.digit_idx, disp.an_n, disp.seg_n}, {3'b0, 2'd0, 4'hF, 7'h7F});
        @(negedge clk);
        reset_n = 1'b1;
        m_val = 16'h0;
        m_edges = 0;
    endtask

    initial begin
        int slot;
        int lit;
        int guard;

        vecs[0] = '{value: 16'h1F2A, seg: {~7'h06, ~7'h71, ~7'h5B, ~7'h77}};
        vecs[1] = '{value: 16'hBEEF, seg: {~7'h7C, ~7'h79, ~7'h79, ~7'h71}};
        vecs[2] = '{value: 16'h8C4D, seg: {~7'h7F, ~7'h39, ~7'h66, ~7'h5E}};
        vecs[3] = '{value: 16'h9035, seg: {~7'h6F, ~7'h3F, ~7'h4F, ~7'h6D}};

        #1;
        do_reset();
        step();
        check("first_an", {12'b0, disp.an_n}, 16'hE);
        check("first_seg", {9'b0, disp.seg_n}, 16'h40);
        for (int i = 0; i < 4 * R; i++) step();

        // Table: load each value, then check every slot of one full frame.
        for (int v = 0; v < 4; v++) begin
            disp.load = 1'b1; disp.value_in = vecs[v].value;
            step();
            disp.load = 1'b0;
            step();
            for (int i = 0; i < 4 * R; i++) begin
                step();
                slot = ((m_edges - 1) / R) % 4;
                check("tbl_seg", {9'b0, disp.seg_n}, {9'b0, vecs[v].seg[slot]});
                check("tbl_an", {12'b0, disp.an_n}, {12'b0, ~(4'b0001 << slot)});
            end
        end

        // Load mid-slot of DIG0: new pattern two edges later, same slot.
        guard = 0;
        while (m_edges % (4 * R) != 1 && guard < 40) begin step(); guard++; end
        disp.load = 1'b1; disp.value_in = 16'h0008;
        step();
        disp.load = 1'b0;
        step();
        check("midslot_an", {12'b0, disp.an_n}, 16'hE);
        check("midslot_seg", {9'b0, disp.seg_n}, 16'h00);

        // Blank window with a load inside it.
        disp.blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            disp.load = (i == 3);
            disp.value_in = 16'hBEEF;
            step();
            check("blank_dark", {3'b0, disp.an_n, disp.seg_n}, {3'b0, 4'hF, 7'h7F});
        end
        disp.load = 1'b0; disp.blank = 1'b0;
        for (int i = 0; i < 4 * R + 1; i++) step();

`ifdef NUM_DISP_LZB_EN
        disp.load = 1'b1; disp.value_in = 16'h0000;
        step();
        disp.load = 1'b0;
        step();
        lit = 0;
        for (int i = 0; i < 4 * R; i++) begin
            step();
            if (disp.an_n != 4'hF) lit++;
        end
        check("lzb_zero_lit", 16'(lit), 16'(R));
        disp.load = 1'b1; disp.value_in = 16'h0100;
        step();
        disp.load = 1'b0;
        step();
        lit = 0;
        for (int i = 0; i < 4 * R; i++) begin
            step();
            if (disp.an_n != 4'hF) lit++;
        end
        check("lzb_100_lit", 16'(lit), 16'(3 * R));
`else
        lit = 0;
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            disp.load     = ($urandom_range(3) == 0);
            disp.value_in = 16'($urandom);
            disp.blank    = ($urandom_range(7) == 0);
            step();
        end
        disp.load = 1'b0; disp.blank = 1'b0;

        // Asynchronous reset while DIG2 is displayed.
        disp.load = 1'b1; disp.value_in = 16'h4567;
        step();
        disp.load = 1'b0;
        guard = 0;
        while (((m_edges - 1) / R) % 4 != 2 && guard < 40) begin step(); guard++; end
        check("pre_rst_idx", {14'b0, disp.digit_idx}, 16'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", {3'b0, disp.digit_idx, disp.an_n, disp.seg_n}, {3'b0, 2'd0, 4'hF, 7'h7F});
        @(negedge clk);
        reset_n = 1'b1;
        m_val = 16'h0;
        m_edges = 0;
        step();
        check("restart", {3'b0, disp.digit_idx, disp.an_n, disp.seg_n}, {3'b0, 2'd0, 4'hE, 7'h40});
        for (int i = 0; i < 4 * R; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
